pipe_clk_ctrl: RTL and testbench

Clock-enable and reset sequencer placed between the board clock/reset and the `PipeLine` CPU core. It gates pipeline advancement through a single `cpu_ce` enable, so the core runs continuously, advances one cycle per step button press, or advances a programmable burst of N cycles. It also produces a stretched, synchronously released core reset and counts executed cycles. This replaces hand-toggled clocking with a synthesizable, parametrised controller usable both on the board and in benches.

---
 rtl/pipe_clk_ctrl.sv | 186 ++++++++++++++++++
 tb/tb_pipe_clk_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_clk_ctrl.sv
// Clock-enable/reset sequencer for the PipeLine core: halt, run, single-step, N-cycle burst; STEP_DEBOUNCE_EN adds a step_btn synchroniser and debounce filter.
// Latency: run/burst enable one cycle after the request is sampled; step enable two cycles after the button edge (plus 2+DBNC_CYC with debounce).
// Backpressure: none; step edges outside step mode and start pulses outside IDLE are dropped, not queued.
module pipe_clk_ctrl #(
    parameter int CNT_W    = 16,
    parameter int RST_HOLD = 4,
    parameter int DBNC_CYC = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       mode,
    input  logic             step_btn,
    input  logic             start,
    input  logic [CNT_W-1:0] burst_len,
    output logic             cpu_rst_n,
    output logic             cpu_ce,
    output logic             busy,
    output logic             done,
    output logic [31:0]      cycle_cnt
);

    localparam logic [1:0] MODE_RUN   = 2'b01;
    localparam logic [1:0] MODE_STEP  = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    localparam int              HW        = $clog2(RST_HOLD + 1);
    localparam logic [HW-1:0]   HOLD_LAST = HW'(RST_HOLD - 1);

    if (RST_HOLD < 1 || DBNC_CYC < 1) begin : g_bad_param
        $error("pipe_clk_ctrl: RST_HOLD and DBNC_CYC must be at least 1");
    end

    typedef enum logic [2:0] {
        S_HOLD,
        S_IDLE,
        S_RUN,
        S_STEP,
        S_BURST
    } state_t;

    state_t           state_q, state_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             rstn_d, ce_d, busy_d, done_d;

    logic             step_clean;
    logic             step_prev;
    logic             step_pls;

`ifdef STEP_DEBOUNCE_EN
    localparam int            DW       = $clog2(DBNC_CYC + 1);
    localparam logic [DW-1:0] DBNC_LAST = DW'(DBNC_CYC - 1);

    logic          sync1, sync2, filt;
    logic [DW-1:0] dcnt;

    // Filter flips only after DBNC_CYC consecutive samples disagree with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            filt  <= 1'b0;
            dcnt  <= '0;
        end else begin
            sync1 <= step_btn;
            sync2 <= sync1;
            if (sync2 == filt) begin
                dcnt <= '0;
            end else if (dcnt == DBNC_LAST) begin
                filt <= sync2;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    assign step_clean = filt;
`else
    assign step_clean = step_btn;
`endif

    // Edges are only kept when IDLE in step mode, so nothing queues up during a step.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            step_prev <= 1'b0;
            step_pls  <= 1'b0;
        end else begin
            step_prev <= step_clean;
            step_pls  <= (state_q == S_IDLE) && (mode == MODE_STEP) &&
                         step_clean && !step_prev;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        rem_d   = rem_q;
        rstn_d  = cpu_rst_n;
        ce_d    = 1'b0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    rstn_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (mode == MODE_RUN) begin
                    state_d = S_RUN;
                    ce_d    = 1'b1;
                end else if (mode == MODE_STEP && step_pls) begin
                    state_d = S_STEP;
                    ce_d    = 1'b1;
                end else if (mode == MODE_BURST && start) begin
                    if (burst_len == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_BURST;
                        ce_d    = 1'b1;
                        busy_d  = 1'b1;
                        rem_d   = burst_len;
                    end
                end
            end
            S_RUN: begin
                if (mode == MODE_RUN) begin
                    ce_d = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_STEP: begin
                state_d = S_IDLE;
            end
            S_BURST: begin
                if (mode != MODE_BURST) begin
                    state_d = S_IDLE;
                end else if (rem_q == CNT_W'(1)) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    rem_d  = rem_q - 1'b1;
                    ce_d   = 1'b1;
                    busy_d = 1'b1;
                end
            end
            default: begin
                state_d = S_HOLD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_HOLD;
            hold_q    <= '0;
            rem_q     <= '0;
            cpu_rst_n <= 1'b0;
            cpu_ce    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            rem_q     <= rem_d;
            cpu_rst_n <= rstn_d;
            cpu_ce    <= ce_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cycle_cnt <= '0;
        end else if (cpu_ce) begin
            cycle_cnt <= cycle_cnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_clk_ctrl.sv
// Directed bench for pipe_clk_ctrl: reset hold, run, step, burst, zero burst, abort, async reset, debounce.
module tb_pipe_clk_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic        step_btn;
    logic        start;
    logic [15:0] burst_len;
    logic        cpu_rst_n;
    logic        cpu_ce;
    logic        busy;
    logic        done;
    logic [31:0] cycle_cnt;

    int total;
    int bad;
    int exp_cnt;

    pipe_clk_ctrl #(
        .CNT_W   (16),
        .RST_HOLD(4),
        .DBNC_CYC(4)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .mode     (mode),
        .step_btn (step_btn),
        .start    (start),
        .burst_len(burst_len),
        .cpu_rst_n(cpu_rst_n),
        .cpu_ce   (cpu_ce),
        .busy     (busy),
        .done     (done),
        .cycle_cnt(cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset;
        rst = 1'b0; mode = 2'b00; step_btn = 1'b0; start = 1'b0; burst_len = '0;
        repeat (3) @(negedge clk);
        total++;
        if (cpu_rst_n !== 1'b0 || cpu_ce !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_outputs: got rst_n=%b ce=%b busy=%b done=%b want 0 0 0 0",
                     cpu_rst_n, cpu_ce, busy, done);
        end
        total++;
        if (cycle_cnt !== 32'd0) begin
            bad++;
            $display("FAIL reset_cycle_cnt: got %0d want 0", cycle_cnt);
        end
        rst = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            total++;
            if (cpu_rst_n !== 1'(i >= 4)) begin
                bad++;
                $display("FAIL hold_edge%0d: got cpu_rst_n=%b want %b", i, cpu_rst_n, i >= 4);
            end
            total++;
            if (cpu_ce !== 1'b0) begin
                bad++;
                $display("FAIL hold_ce%0d: got %b want 0", i, cpu_ce);
            end
        end
        exp_cnt = 0;
    endtask

    task automatic test_run;
        logic [14:0] ce_v;
        ce_v = '0;
        mode = 2'b01;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            ce_v[i] = cpu_ce;
            if (i == 9) mode = 2'b00;
        end
        exp_cnt += 10;
        total++;
        if (ce_v !== 15'h03FF) begin
            bad++;
            $display("FAIL run_ce_pattern: got %h want 03ff", ce_v);
        end
        total++;
        if (cycle_cnt !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL run_cycle_cnt: got %0d want %0d", cycle_cnt, exp_cnt);
        end
    endtask

    task automatic test_step;
        int   n_ce;
        int   n_rise;
        logic prev;
        n_ce = 0; n_rise = 0; prev = 1'b0;
        mode = 2'b10;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 13; i++) begin
                step_btn = (i < 5);
                @(negedge clk);
                if (cpu_ce) n_ce++;
                if (cpu_ce && !prev) n_rise++;
                prev = cpu_ce;
            end
        end
        step_btn = 1'b0;
        exp_cnt += 3;
        total++;
        if (n_ce !== 3 || n_rise !== 3) begin
            bad++;
            $display("FAIL step_pulses: got cycles=%0d pulses=%0d want 3 3", n_ce, n_rise);
        end
        mode = 2'b00;
        n_ce = 0;
        for (int i = 0; i < 15; i++) begin
            step_btn = (i >= 2 && i < 7);
            @(negedge clk);
            if (cpu_ce) n_ce++;
        end
        step_btn = 1'b0;
        mode = 2'b10;
        repeat (6) begin
            @(negedge clk);
            if (cpu_ce) n_ce++;
        end
        mode = 2'b00;
        total++;
        if (n_ce !== 0) begin
            bad++;
            $display("FAIL step_ignored_in_halt: got %0d ce cycles want 0", n_ce);
        end
        total++;
        if (cycle_cnt !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL step_cycle_cnt: got %0d want %0d", cycle_cnt, exp_cnt);
        end
    endtask

    task automatic test_burst;
        logic [9:0] ce_v, busy_v, done_v;
        ce_v = '0; busy_v = '0; done_v = '0;
        mode = 2'b11; burst_len = 16'd5; start = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ce_v[i] = cpu_ce; busy_v[i] = busy; done_v[i] = done;
            if (i == 0) start = 1'b0;
        end
        exp_cnt += 5;
        total++;
        if (ce_v !== 10'b00000_11111) begin
            bad++;
            $display("FAIL burst_ce: got %b want 0000011111", ce_v);
        end
        total++;
        if (busy_v !== 10'b00000_11111) begin
            bad++;
            $display("FAIL burst_busy: got %b want 0000011111", busy_v);
        end
        total++;
        if (done_v !== 10'b00001_00000) begin
            bad++;
            $display("FAIL burst_done: got %b want 0000100000", done_v);
        end
        total++;
        if (cycle_cnt !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL burst_cycle_cnt: got %0d want %0d", cycle_cnt, exp_cnt);
        end
    endtask

    task automatic test_burst_zero;
        logic [5:0] ce_v, busy_v, done_v;
        ce_v = '0; busy_v = '0; done_v = '0;
        burst_len = 16'd0; start = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ce_v[i] = cpu_ce; busy_v[i] = busy; done_v[i] = done;
            if (i == 0) start = 1'b0;
        end
        total++;
        if (done_v !== 6'b000001) begin
            bad++;
            $display("FAIL zero_burst_done: got %b want 000001", done_v);
        end
        total++;
        if (ce_v !== 6'b0 || busy_v !== 6'b0) begin
            bad++;
            $display("FAIL zero_burst_ce: got ce=%b busy=%b want 0 0", ce_v, busy_v);
        end
    endtask

    task automatic test_abort;
        int   n_ce;
        logic done_seen;
        n_ce = 0; done_seen = 1'b0;
        mode = 2'b11; burst_len = 16'd100; start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 0) start = 1'b0;
            if (cpu_ce) begin
                n_ce++;
                if (n_ce == 7) mode = 2'b00;
            end
            done_seen |= done;
        end
        exp_cnt += 7;
        total++;
        if (n_ce !== 7 || done_seen !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL abort: got ce_cycles=%0d done_seen=%b busy=%b want 7 0 0",
                     n_ce, done_seen, busy);
        end
        total++;
        if (cycle_cnt !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL abort_cycle_cnt: got %0d want %0d", cycle_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid;
        logic done_seen;
        done_seen = 1'b0;
        mode = 2'b11; burst_len = 16'd100; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (cpu_ce !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_burst_active: got ce=%b busy=%b want 1 1", cpu_ce, busy);
        end
        #2 rst = 1'b0;
        #1;
        total++;
        if (cpu_rst_n !== 1'b0 || cpu_ce !== 1'b0 || busy !== 1'b0 ||
            done !== 1'b0 || cycle_cnt !== 32'd0) begin
            bad++;
            $display("FAIL async_reset: got rst_n=%b ce=%b busy=%b done=%b cnt=%0d want 0 0 0 0 0",
                     cpu_rst_n, cpu_ce, busy, done, cycle_cnt);
        end
        @(negedge clk);
        rst = 1'b1; mode = 2'b00;
        exp_cnt = 0;
        repeat (4) begin
            @(negedge clk);
            done_seen |= done;
        end
        total++;
        if (cpu_rst_n !== 1'b1 || done_seen !== 1'b0) begin
            bad++;
            $display("FAIL rehold: got rst_n=%b done_seen=%b want 1 0", cpu_rst_n, done_seen);
        end
        mode = 2'b01;
        repeat (3) @(negedge clk);
        mode = 2'b00;
        repeat (3) @(negedge clk);
        exp_cnt += 3;
        total++;
        if (cycle_cnt !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL post_reset_run: got %0d want %0d", cycle_cnt, exp_cnt);
        end
    endtask

`ifdef STEP_DEBOUNCE_EN
    task automatic test_debounce;
        int n_glitch;
        int n_press;
        n_glitch = 0; n_press = 0;
        mode = 2'b10;
        for (int i = 0; i < 22; i++) begin
            step_btn = (i < 2);
            @(negedge clk);
            if (cpu_ce) n_glitch++;
        end
        for (int i = 0; i < 30; i++) begin
            step_btn = (i < 10);
            @(negedge clk);
            if (cpu_ce) n_press++;
        end
        step_btn = 1'b0;
        mode = 2'b00;
        exp_cnt += 1;
        total++;
        if (n_glitch !== 0) begin
            bad++;
            $display("FAIL debounce_glitch: got %0d ce cycles want 0", n_glitch);
        end
        total++;
        if (n_press !== 1) begin
            bad++;
            $display("FAIL debounce_press: got %0d ce cycles want 1", n_press);
        end
        total++;
        if (cycle_cnt !== 32'(exp_cnt)) begin
            bad++;
            $display("FAIL debounce_cycle_cnt: got %0d want %0d", cycle_cnt, exp_cnt);
        end
    endtask
`endif

    initial begin
        total = 0; bad = 0; exp_cnt = 0;
        test_reset;
        test_run;
        test_step;
        test_burst;
        test_burst_zero;
        test_abort;
        test_reset_mid;
`ifdef STEP_DEBOUNCE_EN
        test_debounce;
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
